// File: rtl/issue_ctrl_pkg.sv
// ============================================================================
// Module      : issue_ctrl_pkg
// Description : Shared FSM state encodings for the dual-issue controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package issue_ctrl_pkg;

    typedef enum logic [0:0] {
        ISSUE_ST_RUN   = 1'b0,
        ISSUE_ST_SPLIT = 1'b1
    } issue_state_e;

endpackage

`default_nettype wire

// File: rtl/issue_ctrl.sv
// ============================================================================
// Module      : issue_ctrl
// Description : Dual-issue slot controller; decides per-slot issue, IF hold
//               and pair splitting. Optional ISSUE_PERF_CNT_EN builds a
//               stall-cycle counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module issue_ctrl
    import issue_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dec_valid_1,
    input  logic             dec_valid_2,
    input  logic             stall_raw_1,
    input  logic             stall_raw_2,
    input  logic             pair_dep,
    input  logic             flush,
    output logic             issue_en_1,
    output logic             issue_en_2,
    output logic             if_hold,
    output logic             split_pending,
    output logic [CNT_W-1:0] stall_cnt
);

    issue_state_e state_q;
    issue_state_e state_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ISSUE_ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        issue_en_1 = 1'b0;
        issue_en_2 = 1'b0;
        if_hold    = 1'b0;
        // Outputs are Mealy, so reset must mask them combinationally.
        if (rst) begin
            state_d = ISSUE_ST_RUN;
        end else begin
            case (state_q)
                ISSUE_ST_RUN: begin
                    if (flush || !dec_valid_1) begin
                        state_d = ISSUE_ST_RUN;
                    end else if (stall_raw_1) begin
                        if_hold = 1'b1;
                    end else if (dec_valid_2 && (stall_raw_2 || pair_dep)) begin
                        issue_en_1 = 1'b1;
                        if_hold    = 1'b1;
                        state_d    = ISSUE_ST_SPLIT;
                    end else begin
                        issue_en_1 = 1'b1;
                        issue_en_2 = dec_valid_2;
                    end
                end
                ISSUE_ST_SPLIT: begin
                    if (flush) begin
                        state_d = ISSUE_ST_RUN;
                    end else if (stall_raw_2) begin
                        if_hold = 1'b1;
                    end else begin
                        issue_en_2 = 1'b1;
                        state_d    = ISSUE_ST_RUN;
                    end
                end
                default: begin
                    state_d = ISSUE_ST_RUN;
                end
            endcase
        end
    end

    assign split_pending = (state_q == ISSUE_ST_SPLIT);

`ifdef ISSUE_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (if_hold) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_issue_ctrl.sv
// ============================================================================
// Module      : tb_issue_ctrl
// Description : Directed self-checking bench for issue_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_issue_ctrl;

    localparam int CNT_W = 32;
`ifdef ISSUE_PERF_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             dec_valid_1 = 1'b0;
    logic             dec_valid_2 = 1'b0;
    logic             stall_raw_1 = 1'b0;
    logic             stall_raw_2 = 1'b0;
    logic             pair_dep = 1'b0;
    logic             flush = 1'b0;
    logic             issue_en_1;
    logic             issue_en_2;
    logic             if_hold;
    logic             split_pending;
    logic [CNT_W-1:0] stall_cnt;

    int tests = 0;
    int fails = 0;

    issue_ctrl #(.CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .dec_valid_1   (dec_valid_1),
        .dec_valid_2   (dec_valid_2),
        .stall_raw_1   (stall_raw_1),
        .stall_raw_2   (stall_raw_2),
        .pair_dep      (pair_dep),
        .flush         (flush),
        .issue_en_1    (issue_en_1),
        .issue_en_2    (issue_en_2),
        .if_hold       (if_hold),
        .split_pending (split_pending),
        .stall_cnt     (stall_cnt)
    );

    always #5 clk = ~clk;

    // Inputs change 1 time unit after a rising edge; outputs are sampled 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v1, input logic v2, input logic r1,
                         input logic r2, input logic pd, input logic fl);
        dec_valid_1 = v1;
        dec_valid_2 = v2;
        stall_raw_1 = r1;
        stall_raw_2 = r2;
        pair_dep    = pd;
        flush       = fl;
        #1;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1, 1, 0, 0, 0, 0);
        tests++;
        if ({issue_en_1, issue_en_2, if_hold, split_pending} !== 4'b0000) begin
            fails++;
            $display("FAIL reset_outputs: got %b want 0000",
                     {issue_en_1, issue_en_2, if_hold, split_pending});
        end
        tests++;
        if (stall_cnt !== '0) begin
            fails++;
            $display("FAIL reset_cnt: got %0d want 0", stall_cnt);
        end
        do_reset();
    endtask

    task automatic test_no_hazard();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 0, 0, 0, 0);
            tests++;
            if ({issue_en_1, issue_en_2, if_hold, split_pending} !== 4'b1100) begin
                fails++;
                $display("FAIL no_hazard[%0d]: got %b want 1100", i,
                         {issue_en_1, issue_en_2, if_hold, split_pending});
            end
            tick();
        end
        tests++;
        if (stall_cnt !== '0) begin
            fails++;
            $display("FAIL no_hazard_cnt: got %0d want 0", stall_cnt);
        end
    endtask

    task automatic test_load_use_1();
        do_reset();
        drive(1, 1, 1, 0, 0, 0);
        tests++;
        if ({issue_en_1, issue_en_2, if_hold, split_pending} !== 4'b0010) begin
            fails++;
            $display("FAIL load_use_stall: got %b want 0010",
                     {issue_en_1, issue_en_2, if_hold, split_pending});
        end
        tick();
        drive(1, 1, 0, 0, 0, 0);
        tests++;
        if ({issue_en_1, issue_en_2, if_hold, split_pending} !== 4'b1100) begin
            fails++;
            $display("FAIL load_use_resume: got %b want 1100",
                     {issue_en_1, issue_en_2, if_hold, split_pending});
        end
        tick();
        tests++;
        if (stall_cnt !== (CNT_ON ? 32'd1 : 32'd0)) begin
            fails++;
            $display("FAIL load_use_cnt: got %0d want %0d", stall_cnt, CNT_ON ? 1 : 0);
        end
    endtask

    task automatic test_pair_dep();
        do_reset();
        drive(1, 1, 0, 0, 1, 0);
        tests++;
        if ({issue_en_1, issue_en_2, if_hold, split_pending} !== 4'b1010) begin
            fails++;
            $display("FAIL pair_dep_c0: got %b want 1010",
                     {issue_en_1, issue_en_2, if_hold, split_pending});
        end
        tick();
        drive(1, 1, 0, 0, 0, 0);
        tests++;
        if ({issue_en_1, issue_en_2, if_hold, split_pending} !== 4'b0101) begin
            fails++;
            $display("FAIL pair_dep_c1: got %b want 0101",
                     {issue_en_1, issue_en_2, if_hold, split_pending});
        end
        tick();
        tests++;
        if ({issue_en_1, issue_en_2, if_hold, split_pending} !== 4'b1100) begin
            fails++;
            $display("FAIL pair_dep_c2: got %b want 1100",
                     {issue_en_1, issue_en_2, if_hold, split_pending});
        end
        tests++;
        if (stall_cnt !== (CNT_ON ? 32'd1 : 32'd0)) begin
            fails++;
            $display("FAIL pair_dep_cnt: got %0d want %0d", stall_cnt, CNT_ON ? 1 : 0);
        end
    endtask

    task automatic test_load_pair();
        do_reset();
        drive(1, 1, 0, 0, 1, 0);
        tick();
        drive(1, 1, 1, 1, 1, 0);
        tests++;
        if ({issue_en_1, issue_en_2, if_hold, split_pending} !== 4'b0011) begin
            fails++;
            $display("FAIL load_pair_bubble: got %b want 0011",
                     {issue_en_1, issue_en_2, if_hold, split_pending});
        end
        tick();
        drive(1, 1, 1, 0, 1, 0);
        tests++;
        if ({issue_en_1, issue_en_2, if_hold, split_pending} !== 4'b0101) begin
            fails++;
            $display("FAIL load_pair_issue2: got %b want 0101",
                     {issue_en_1, issue_en_2, if_hold, split_pending});
        end
        tick();
        drive(0, 0, 0, 0, 0, 0);
        tests++;
        if (split_pending !== 1'b0 || stall_cnt !== (CNT_ON ? 32'd2 : 32'd0)) begin
            fails++;
            $display("FAIL load_pair_end: got split=%b cnt=%0d want split=0 cnt=%0d",
                     split_pending, stall_cnt, CNT_ON ? 2 : 0);
        end
    endtask

    task automatic test_flush();
        do_reset();
        drive(1, 1, 1, 1, 1, 1);
        tests++;
        if ({issue_en_1, issue_en_2, if_hold, split_pending} !== 4'b0000) begin
            fails++;
            $display("FAIL flush_run: got %b want 0000",
                     {issue_en_1, issue_en_2, if_hold, split_pending});
        end
        tick();
        drive(1, 1, 0, 0, 1, 0);
        tick();
        drive(1, 1, 0, 1, 0, 1);
        tests++;
        if ({issue_en_1, issue_en_2, if_hold, split_pending} !== 4'b0001) begin
            fails++;
            $display("FAIL flush_split: got %b want 0001",
                     {issue_en_1, issue_en_2, if_hold, split_pending});
        end
        tick();
        drive(0, 0, 0, 1, 0, 0);
        tests++;
        if ({issue_en_1, issue_en_2, if_hold, split_pending} !== 4'b0000) begin
            fails++;
            $display("FAIL flush_after: got %b want 0000",
                     {issue_en_1, issue_en_2, if_hold, split_pending});
        end
    endtask

    task automatic test_single_slot();
        do_reset();
        drive(0, 0, 1, 1, 1, 0);
        tests++;
        if ({issue_en_1, issue_en_2, if_hold, split_pending} !== 4'b0000) begin
            fails++;
            $display("FAIL invalid_slot1: got %b want 0000",
                     {issue_en_1, issue_en_2, if_hold, split_pending});
        end
        drive(1, 0, 0, 1, 1, 0);
        tests++;
        if ({issue_en_1, issue_en_2, if_hold, split_pending} !== 4'b1000) begin
            fails++;
            $display("FAIL single_slot: got %b want 1000",
                     {issue_en_1, issue_en_2, if_hold, split_pending});
        end
        tick();
        tests++;
        if (split_pending !== 1'b0) begin
            fails++;
            $display("FAIL single_slot_state: got %b want 0", split_pending);
        end
    endtask

    task automatic test_reset_mid_split();
        do_reset();
        drive(1, 1, 0, 0, 1, 0);
        tick();
        drive(1, 1, 0, 1, 0, 0);
        tests++;
        if ({issue_en_1, issue_en_2, if_hold, split_pending} !== 4'b0011) begin
            fails++;
            $display("FAIL mid_split_pre: got %b want 0011",
                     {issue_en_1, issue_en_2, if_hold, split_pending});
        end
        rst = 1'b1;
        #1;
        tests++;
        if ({issue_en_1, issue_en_2, if_hold, split_pending} !== 4'b0000 || stall_cnt !== '0) begin
            fails++;
            $display("FAIL mid_split_rst: got %b cnt=%0d want 0000 cnt=0",
                     {issue_en_1, issue_en_2, if_hold, split_pending}, stall_cnt);
        end
        tick();
        rst = 1'b0;
        drive(1, 1, 0, 0, 0, 0);
        tests++;
        if ({issue_en_1, issue_en_2, if_hold, split_pending} !== 4'b1100 || stall_cnt !== '0) begin
            fails++;
            $display("FAIL mid_split_release: got %b cnt=%0d want 1100 cnt=0",
                     {issue_en_1, issue_en_2, if_hold, split_pending}, stall_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_no_hazard();
        test_load_use_1();
        test_pair_dep();
        test_load_pair();
        test_flush();
        test_single_slot();
        test_reset_mid_split();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
